// File: rtl/uart_tx.sv
// uart_tx: parametrised UART transmitter with an internal FIFO.
//
// Words are queued through a valid/ready handshake and sent LSB-first as
// start, data, optional parity and stop bits. While the FIFO holds data,
// frames are sent back-to-back with no idle gap.
//
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, a parity
// bit follows the data bits. parity_odd=1 selects odd parity and
// parity_odd=0 selects even parity. When the macro is undefined, no parity
// bit is sent.
//
// Ports:
//   clock   - single clock; all logic runs on the rising edge
//   reset   - synchronous, active-high; empties the FIFO and aborts any frame
//   data_in - word to queue (data_bits wide)
//   valid   - data_in is valid this cycle
//   ready   - FIFO not full; a word is accepted on an edge with valid && ready
//   count   - current FIFO occupancy
//   busy    - the serialiser is in the middle of a frame
//   done    - one-cycle pulse on the edge that ends each frame
//   pin     - serial line; idles high
module uart_tx #(
  parameter int clocks_per_bit = 1,
  parameter int data_bits      = 8,
  parameter int stop_bits      = 1,
  parameter int fifo_depth     = 4,
  parameter int parity_odd     = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [data_bits-1:0]        data_in,
  input  logic                        valid,
  output logic                        ready,
  output logic [$clog2(fifo_depth):0] count,
  output logic                        busy,
  output logic                        done,
  output logic                        pin
);

  localparam int addr_w = $clog2(fifo_depth);
  localparam int cyc_w  = $clog2(clocks_per_bit) + 1;
  localparam int idx_w  = $clog2(data_bits) + 1;
  localparam logic [cyc_w-1:0] cyc_last = cyc_w'(clocks_per_bit - 1);

  // Reject parameter sets the serialiser cannot handle.
  if (clocks_per_bit < 1 || data_bits < 5 || data_bits > 9 ||
      (stop_bits != 1 && stop_bits != 2) || fifo_depth < 2 ||
      (fifo_depth & (fifo_depth - 1)) != 0 ||
      (parity_odd != 0 && parity_odd != 1)) begin : g_illegal_config
    $error("uart_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [cyc_w-1:0]      cyc_q, cyc_d;
  logic [idx_w-1:0]      idx_q, idx_d;
  logic [data_bits-1:0]  shift_q, shift_d;
  logic                  pin_q, pin_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [addr_w:0]       count_q, count_d;
  logic [addr_w-1:0]     wr_ptr_q, wr_ptr_d;
  logic [addr_w-1:0]     rd_ptr_q, rd_ptr_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic [data_bits-1:0]  mem_q [fifo_depth];

  logic push;
  logic pop;
  logic bit_end;

  assign ready = (count_q != (addr_w + 1)'(fifo_depth));
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign pin   = pin_q;

  // Next-state logic for the serialiser and the FIFO pointers. A pop is
  // requested from IDLE, or at the end of the last stop bit so the next start
  // bit begins on the same edge as done.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pin_d    = pin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    pop      = 1'b0;
    push     = valid && ready;
    bit_end  = (cyc_q == cyc_last);

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pin_d  = 1'b1;
        busy_d = 1'b0;
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          pin_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == idx_w'(data_bits - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            pin_d   = parity_q;
`else
            state_d = S_STOP;
            pin_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            pin_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          pin_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == idx_w'(stop_bits - 1)) begin
            done_d = 1'b1;
            idx_d  = '0;
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              pin_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pin_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Latch the head word at pop so later FIFO writes cannot disturb the frame.
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      state_d  = S_START;
      pin_d    = 1'b0;
      busy_d   = 1'b1;
      cyc_d    = '0;
      idx_d    = '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = (^mem_q[rd_ptr_q]) ^ 1'(parity_odd);
`endif
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State and output registers; reset aborts the frame with the line high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      pin_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      pin_q    <= pin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // FIFO storage; pointer reset is enough to discard its contents.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed testbench for uart_tx.
// dut_a: clocks_per_bit=4, data_bits=8, stop_bits=1, fifo_depth=4, even parity.
// dut_b: clocks_per_bit=1, data_bits=5, stop_bits=2, fifo_depth=4.
// dut_c (parity builds only): like dut_a but with odd parity.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int par_bits = 1;
`else
  localparam int par_bits = 0;
`endif
  localparam int nbits_a = 10 + par_bits;
  localparam int frame_a = nbits_a * 4;

  typedef struct packed {
    logic       pin;
    logic       ready;
    logic       busy;
    logic       done;
    logic [2:0] count;
  } obs_t;

  localparam obs_t idle_obs = '{pin: 1'b1, ready: 1'b1, busy: 1'b0, done: 1'b0, count: 3'd0};

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       valid_a, ready_a, busy_a, done_a, pin_a;
  logic [7:0] data_a;
  logic [2:0] count_a;
  logic       valid_b, ready_b, busy_b, done_b, pin_b;
  logic [4:0] data_b;
  logic [2:0] count_b;

  uart_tx #(.clocks_per_bit(4), .data_bits(8), .stop_bits(1), .fifo_depth(4), .parity_odd(0)) dut_a (
    .clock(clock), .reset(reset), .data_in(data_a), .valid(valid_a), .ready(ready_a),
    .count(count_a), .busy(busy_a), .done(done_a), .pin(pin_a));

  uart_tx #(.clocks_per_bit(1), .data_bits(5), .stop_bits(2), .fifo_depth(4), .parity_odd(0)) dut_b (
    .clock(clock), .reset(reset), .data_in(data_b), .valid(valid_b), .ready(ready_b),
    .count(count_b), .busy(busy_b), .done(done_b), .pin(pin_b));

`ifdef UART_TX_PARITY_EN
  logic       valid_c, ready_c, busy_c, done_c, pin_c;
  logic [7:0] data_c;
  logic [2:0] count_c;

  uart_tx #(.clocks_per_bit(4), .data_bits(8), .stop_bits(1), .fifo_depth(4), .parity_odd(1)) dut_c (
    .clock(clock), .reset(reset), .data_in(data_c), .valid(valid_c), .ready(ready_c),
    .count(count_c), .busy(busy_c), .done(done_c), .pin(pin_c));
`endif

  int sel;
  int checks = 0;
  int errors = 0;
  logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  // Outputs of the currently selected instance.
  function automatic obs_t sample();
    obs_t o;
    o = '{pin_a, ready_a, busy_a, done_a, count_a};
    if (sel == 1) o = '{pin_b, ready_b, busy_b, done_b, count_b};
`ifdef UART_TX_PARITY_EN
    if (sel == 2) o = '{pin_c, ready_c, busy_c, done_c, count_c};
`endif
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Holds one word on the selected instance's input for one edge.
  task automatic applyStimulus(input int s, input logic [8:0] w);
    sel = s;
    if (s == 0) begin data_a = w[7:0]; valid_a = 1'b1; end
    if (s == 1) begin data_b = w[4:0]; valid_b = 1'b1; end
`ifdef UART_TX_PARITY_EN
    if (s == 2) begin data_c = w[7:0]; valid_c = 1'b1; end
`endif
    step();
    valid_a = 1'b0;
    valid_b = 1'b0;
`ifdef UART_TX_PARITY_EN
    valid_c = 1'b0;
`endif
  endtask

  // Entered on the sample right after the edge where pin fell.
  task automatic checkFrame(input string tag, input int cpb, input logic [15:0] bits, input int nbits);
    for (int j = 0; j < cpb * nbits; j++) begin
      checkOutput({tag, "_pin"}, sample().pin, bits[j / cpb]);
      checkOutput({tag, "_done_early"}, sample().done, 1'b0);
      checkOutput({tag, "_busy"}, sample().busy, 1'b1);
      step();
    end
    checkOutput({tag, "_done"}, sample().done, 1'b1);
  endtask

  // Single isolated frame: accept edge, pop edge, full frame, return to idle.
  task automatic runFrame(input int s, input logic [8:0] w, input int cpb,
                          input logic [15:0] bits, input int nbits, input string tag);
    applyStimulus(s, w);
    checkOutput({tag, "_count1"}, sample().count, 3'd1);
    checkOutput({tag, "_pin_before_pop"}, sample().pin, 1'b1);
    step();
    checkFrame(tag, cpb, bits, nbits);
    checkOutput({tag, "_busy_end"}, sample().busy, 1'b0);
    checkOutput({tag, "_pin_end"}, sample().pin, 1'b1);
    step();
    checkOutput({tag, "_done_once"}, sample().done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sel = 0;
    reset = 1'b1;
    valid_a = 1'b0; data_a = '0;
    valid_b = 1'b0; data_b = '0;
`ifdef UART_TX_PARITY_EN
    valid_c = 1'b0; data_c = '0;
`endif
    step();
    step();

    $display("[TB] reset values and idle stability");
    sel = 0; checkOutput("reset_a", sample(), idle_obs);
    sel = 1; checkOutput("reset_b", sample(), idle_obs);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      sel = 0; checkOutput("idle_a", sample(), idle_obs);
      sel = 1; checkOutput("idle_b", sample(), idle_obs);
    end

    $display("[TB] frame 0xA5");
    runFrame(0, 9'h0A5, 4, (par_bits != 0) ? 16'h054A : 16'h034A, nbits_a, "a5");

    $display("[TB] short configuration 0x13");
    runFrame(1, 9'h013, 1, (par_bits != 0) ? 16'h01E6 : 16'h00E6, 8 + par_bits, "short");

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity 0x07");
    runFrame(0, 9'h007, 4, 16'h060E, 11, "par_even");
    runFrame(2, 9'h007, 4, 16'h040E, 11, "par_odd");
`endif

    $display("[TB] FIFO backpressure");
    sel = 0;
    fork
      begin : producer
        int t;
        for (int i = 0; i < 5; i++) begin
          data_a = words[i];
          valid_a = 1'b1;
          checkOutput($sformatf("bp_ready_w%0d", i + 1), ready_a, 1'b1);
          step();
        end
        data_a = words[5];
        checkOutput("bp_full_ready", ready_a, 1'b0);
        checkOutput("bp_full_count", count_a, 3'd4);
        t = 0;
        while (ready_a !== 1'b1 && t < 200) begin
          step();
          t++;
        end
        checkOutput("bp_w6_timeout", (t < 200) ? 1'b0 : 1'b1, 1'b0);
        checkOutput("bp_w6_with_done", done_a, 1'b1);
        step();
        valid_a = 1'b0;
      end
      begin : consumer
        int t;
        logic [7:0] got;
        t = 0;
        while (pin_a !== 1'b0 && t < 10) begin
          step();
          t++;
        end
        checkOutput("bp_start_timeout", (t < 10) ? 1'b0 : 1'b1, 1'b0);
        for (int f = 0; f < 6; f++) begin
          got = '0;
          checkOutput($sformatf("bp_gap_f%0d", f), done_a, (f > 0) ? 1'b1 : 1'b0);
          for (int j = 0; j < frame_a; j++) begin
            if (j > 0) checkOutput("bp_done_early", done_a, 1'b0);
            if (j % 4 == 2) begin
              if (j / 4 == 0) checkOutput("bp_start_bit", pin_a, 1'b0);
              else if (j / 4 <= 8) got[j / 4 - 1] = pin_a;
              else if (j / 4 == nbits_a - 1) checkOutput("bp_stop_bit", pin_a, 1'b1);
            end
            step();
          end
          checkOutput($sformatf("bp_done_f%0d", f), done_a, 1'b1);
          checkOutput($sformatf("bp_data_f%0d", f), got, words[f]);
        end
        checkOutput("bp_busy_end", busy_a, 1'b0);
      end
    join
    step();

    $display("[TB] reset mid-frame");
    sel = 0;
    data_a = words[0]; valid_a = 1'b1; step();
    data_a = words[1]; step();
    data_a = words[2]; step();
    valid_a = 1'b0;
    checkOutput("mid_count2", count_a, 3'd2);
    checkOutput("mid_pin_start", pin_a, 1'b0);
    for (int i = 0; i < 16; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mid_reset", sample(), idle_obs);
    for (int i = 0; i < 50; i++) begin
      step();
      checkOutput("mid_quiet", {done_a, pin_a, busy_a}, 3'b010);
    end
    runFrame(0, 9'h0A5, 4, (par_bits != 0) ? 16'h054A : 16'h034A, nbits_a, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Parametrised UART transmitter that succeeds the fixed 8N1 transmitter. It accepts words through a valid/ready handshake into an internal FIFO and serialises them LSB-first onto a single line. Frames are sent back-to-back with no idle gap while the FIFO holds data. Data width, stop-bit count, bit period and queue depth are configurable, and an optional parity bit is compiled in by macro. It sits between on-chip producers (telemetry, debug) and the board-level TX pin.

## Interface
- clocks_per_bit, 1, clock cycles per bit on the line; ≥1
- data_bits, 8, data bits per frame; 5..9
- stop_bits, 1, stop bits per frame; 1 or 2
- fifo_depth, 4, queued words; power of two, ≥2
- parity_odd, 0, 1 = odd parity, 0 = even; only used with UART_TX_PARITY_EN
- clock  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- data_in  input  data_bits  word to queue
- valid  input  1  data_in is valid this cycle
- ready  output  1  FIFO not full; a word is accepted on an edge with valid && ready
- count  output  $clog2(fifo_depth)+1  current FIFO occupancy
- busy  output  1  serialiser is mid-frame
- done  output  1  one-cycle pulse at the end of each frame
- pin  output  1  serial line; idles high

## Operation
- Reset values: pin=1, busy=0, done=0, count=0, ready=1. Reset also empties the FIFO and puts the serialiser in IDLE.
- FIFO:
  - ready = (count != fifo_depth), decoded combinationally from count.
  - Pointers wrap modulo fifo_depth.
  - Push and pop on the same edge leave count unchanged.
  - When full, ready is low and no write-through occurs; ready rises the cycle after a pop.
- Serialiser states: IDLE → START → DATA → [PARITY] → STOP.
  - Each bit lasts exactly clocks_per_bit cycles.
  - The bit counter is $clog2(clocks_per_bit)+1 bits wide, so clocks_per_bit=1 must work.
- IDLE: when count≠0, pop the head word into the shift register, drive pin=0, set busy=1 and enter START.
- START: pin=0 for one bit period, then go to DATA.
- DATA: pin = shift[0], shifting right once per bit for data_bits bits.
- PARITY (macro only): pin = XOR of the data bits, XOR parity_odd.
- STOP: pin=1 for stop_bits bit periods. On the edge that ends the last stop period:
  - done=1 for exactly that one cycle;
  - if count≠0, pop the next word and go directly to START, with pin=0 on the same edge and busy staying 1;
  - otherwise go to IDLE with busy=0.
- The frame word is latched at pop, so data_in and the FIFO contents may change mid-frame.
- Reset mid-frame:
  - pin=1 on that edge;
  - the frame is aborted and no done pulse is produced;
  - FIFO contents are discarded.

## Timing
- Accept edge N with the FIFO empty and the serialiser idle: count=1 after N; pop at edge N+1, where pin falls and busy rises.
- Frame length F = (1 + data_bits + P + stop_bits) × clocks_per_bit cycles, where P = 1 with parity and 0 otherwise.
- done is asserted F cycles after the edge where pin fell.
- Back-to-back frames: the next start bit begins on the same edge as done, so the line has zero idle cycles.
- Sustained throughput is one word per F cycles.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is included, P=1, and parity_odd selects the parity sense.
- Not defined: no PARITY state, P=0, and parity_odd is ignored.

## Test plan
- Reset (with valid held low) → pin=1, ready=1, busy=0, count=0, done=0; values stay stable for 20 cycles.
- Frame format, with clocks_per_bit=4, data_bits=8, stop_bits=1, no parity:
  - stimulus: push 0xA5;
  - pin = 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles;
  - done pulses 40 cycles after the falling edge;
  - busy then drops to 0.
- FIFO backpressure, with fifo_depth=4:
  - stimulus: push 6 words back-to-back;
  - words 1–5 are accepted, and ready goes low with count=4;
  - word 6 is held until the first done, then accepted;
  - 6 frames go out in order with no idle gap, producing 6 done pulses F cycles apart.
- Parity, with UART_TX_PARITY_EN defined:
  - stimulus: push 0x07;
  - with parity_odd=0, the parity bit is 1;
  - with parity_odd=1, the parity bit is 0;
  - F=44 at clocks_per_bit=4.
- Short configuration, with clocks_per_bit=1, data_bits=5, stop_bits=2:
  - stimulus: push 0x13;
  - pin = 0,1,1,0,0,1,1,1 over 8 cycles;
  - done on the 8th edge.
- Reset mid-frame:
  - stimulus: assert reset during the DATA bit 3 period with 2 words queued;
  - pin=1, count=0, busy=0 on the next edge;
  - no done pulse occurs;
  - a fresh push afterwards produces a correct full frame.
